rate_lock_tracker: RTL and testbench

RATE_LOCK_TRACKER -- requirements
Module: rate_lock_tracker

---
 rtl/rate_lock_tracker.sv | 237 +++++++++++++++++++++++
 tb/tb_rate_lock_tracker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_lock_tracker.sv
// Edge-to-edge half-rate tracker: acquires, locks onto, and averages the spacing of recovered edges.
// Build option RATE_LOCK_TRACKER_PWM_EN keeps separate last-sample registers for the high and low phases.
package common_p;
  typedef struct packed {
    logic clk;
    logic sync_rst;
    logic clk_en;
  } clk_dom;
endpackage

module rate_lock_tracker #(
  parameter int COUNTER_WIDTH  = 16,
  parameter int AVG_DEPTH_LOG2 = 2,
  parameter int LOCK_COUNT     = 4
) (
  input  common_p::clk_dom           sys_dom_i,
  input  logic                       track_en_i,
  input  logic                       edge_i,
  input  logic                       edge_level_i,
  input  logic                       pause_polarity_i,
  input  logic [COUNTER_WIDTH-1:0]   minimum_half_rate_minus_one_i,
  input  logic [COUNTER_WIDTH-1:0]   maximum_half_rate_minus_one_i,
  input  logic [COUNTER_WIDTH-1:0]   minimum_pause_cycles_i,
  output logic                       busy_o,
  output logic                       locked_o,
  output logic                       paused_o,
  output logic [COUNTER_WIDTH-1:0]   half_rate_minus_one_o,
  output logic                       half_rate_valid_o,
  output logic [COUNTER_WIDTH-1:0]   high_half_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0]   low_half_rate_minus_one_o,
  output logic                       violation_o,
  output logic [1:0]                 violation_code_o
);

  localparam int DEPTH  = 1 << AVG_DEPTH_LOG2;
  localparam int SUM_W  = COUNTER_WIDTH + AVG_DEPTH_LOG2;
  localparam int LCNT_W = $clog2(LOCK_COUNT + 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
  localparam logic [LCNT_W-1:0]        LOCK_TGT = LCNT_W'(LOCK_COUNT);
  localparam logic [LCNT_W-1:0]        LOCK_ONE = LCNT_W'(1);

  if (LOCK_COUNT < DEPTH) begin : g_bad_cfg
    $error("rate_lock_tracker: LOCK_COUNT must be >= 2**AVG_DEPTH_LOG2");
  end

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, PAUSED} state_t;

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [COUNTER_WIDTH-1:0] avg_trunc(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:AVG_DEPTH_LOG2];
  endfunction

  logic clk, rst, en;
  assign clk = sys_dom_i.clk;
  assign rst = sys_dom_i.sync_rst;
  assign en  = sys_dom_i.clk_en;

  state_t                    state_q, state_n;
  logic [COUNTER_WIDTH-1:0]  cnt_q, cnt_n;
  logic                      started_q, started_n;
  logic [LCNT_W-1:0]         lock_q, lock_n, lock_inc;
  logic [COUNTER_WIDTH-1:0]  hist [DEPTH];
  logic [SUM_W-1:0]          sum_q;

  logic [COUNTER_WIDTH-1:0]  sample_p0;
  logic [SUM_W-1:0]          sum_p0;
  logic                      too_short_p0, too_long_p0, in_bound_p0;
  logic                      push_p0, clear_p0;
  logic [COUNTER_WIDTH-1:0]  rate_p0;
  logic                      vld_p0, viol_p0;
  logic [1:0]                code_p0;

  logic [COUNTER_WIDTH-1:0]  rate_p1;
  logic                      vld_p1, viol_p1;
  logic [1:0]                code_p1;
  logic                      busy_p1, locked_p1, paused_p1;

  // stage p0: classify the gap count captured at this edge
  assign sample_p0    = cnt_q;
  assign too_short_p0 = sample_p0 < minimum_half_rate_minus_one_i;
  assign too_long_p0  = sample_p0 > maximum_half_rate_minus_one_i;
  assign in_bound_p0  = !too_short_p0 && !too_long_p0;
  assign sum_p0       = sum_q + SUM_W'(sample_p0) - SUM_W'(hist[DEPTH-1]);
  assign lock_inc     = lock_q + LOCK_ONE;

  always_comb begin
    state_n   = state_q;
    cnt_n     = edge_i ? '0 : sat_inc(cnt_q);
    started_n = started_q;
    lock_n    = lock_q;
    push_p0   = 1'b0;
    clear_p0  = 1'b0;
    rate_p0   = rate_p1;
    vld_p0    = 1'b0;
    viol_p0   = 1'b0;
    code_p0   = 2'b00;
    case (state_q)
      IDLE: begin
        if (track_en_i) begin
          state_n   = ACQUIRE;
          started_n = 1'b0;
        end
      end
      ACQUIRE: begin
        if (edge_i) begin
          if (!started_q) begin
            started_n = 1'b1;
          end else if (in_bound_p0) begin
            push_p0 = 1'b1;
            vld_p0  = 1'b1;
            rate_p0 = sample_p0;
            lock_n  = lock_inc;
            if (lock_inc == LOCK_TGT) state_n = LOCKED;
          end else begin
            viol_p0  = 1'b1;
            code_p0  = too_short_p0 ? 2'b01 : 2'b10;
            lock_n   = '0;
            clear_p0 = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (edge_i) begin
          if (in_bound_p0) begin
            push_p0 = 1'b1;
            vld_p0  = 1'b1;
            rate_p0 = avg_trunc(sum_p0);
          end else begin
            viol_p0   = 1'b1;
            code_p0   = too_short_p0 ? 2'b01 : 2'b10;
            state_n   = ACQUIRE;
            lock_n    = '0;
            clear_p0  = 1'b1;
            started_n = 1'b0;
          end
        end else if (edge_level_i == pause_polarity_i) begin
          if (cnt_q >= minimum_pause_cycles_i) state_n = PAUSED;
        end else if (cnt_q > maximum_half_rate_minus_one_i) begin
          viol_p0   = 1'b1;
          code_p0   = 2'b11;
          state_n   = ACQUIRE;
          lock_n    = '0;
          clear_p0  = 1'b1;
          started_n = 1'b0;
        end
      end
      PAUSED: begin
        // the sample spanning the pause is dropped; the edge only restarts the count
        if (edge_i) state_n = LOCKED;
      end
      default: state_n = IDLE;
    endcase
    if (!track_en_i) begin
      state_n   = IDLE;
      cnt_n     = '0;
      started_n = 1'b0;
      lock_n    = '0;
      push_p0   = 1'b0;
      clear_p0  = 1'b1;
      vld_p0    = 1'b0;
      viol_p0   = 1'b0;
      code_p0   = 2'b00;
      rate_p0   = rate_p1;
    end
  end

  // stage p1: state, history and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      started_q <= 1'b0;
      lock_q    <= '0;
      sum_q     <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      rate_p1   <= '0;
      vld_p1    <= 1'b0;
      viol_p1   <= 1'b0;
      code_p1   <= 2'b00;
      busy_p1   <= 1'b0;
      locked_p1 <= 1'b0;
      paused_p1 <= 1'b0;
    end else if (en) begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      started_q <= started_n;
      lock_q    <= lock_n;
      if (clear_p0) begin
        sum_q <= '0;
        for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      end else if (push_p0) begin
        sum_q <= sum_p0;
        for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= sample_p0;
      end
      rate_p1   <= rate_p0;
      vld_p1    <= vld_p0;
      viol_p1   <= viol_p0;
      code_p1   <= code_p0;
      busy_p1   <= (state_n != IDLE);
      locked_p1 <= (state_n == LOCKED) || (state_n == PAUSED);
      paused_p1 <= (state_n == PAUSED);
    end
  end

`ifdef RATE_LOCK_TRACKER_PWM_EN
  logic [COUNTER_WIDTH-1:0] high_p1, low_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      high_p1 <= '0;
      low_p1  <= '0;
    end else if (en && push_p0) begin
      if (!edge_level_i) high_p1 <= sample_p0;
      else               low_p1  <= sample_p0;
    end
  end

  assign high_half_rate_minus_one_o = high_p1;
  assign low_half_rate_minus_one_o  = low_p1;
`else
  assign high_half_rate_minus_one_o = '0;
  assign low_half_rate_minus_one_o  = '0;
`endif

  assign busy_o                = busy_p1;
  assign locked_o              = locked_p1;
  assign paused_o              = paused_p1;
  assign half_rate_minus_one_o = rate_p1;
  assign half_rate_valid_o     = vld_p1;
  assign violation_o           = viol_p1;
  assign violation_code_o      = code_p1;

endmodule

// File: tb/tb_rate_lock_tracker.sv
// Scoreboard bench for rate_lock_tracker: sample and violation pulses are queued with their due cycle.
module tb_rate_lock_tracker;

  logic clk, rst, en;
  logic track_en, edge_in, edge_level, pause_pol;
  logic [15:0] min_hr, max_hr, pause_cyc;
  logic busy, locked, paused, hr_valid, viol;
  logic [15:0] hr, high_hr, low_hr;
  logic [1:0] viol_code;
  common_p::clk_dom dom;

  assign dom = '{clk: clk, sync_rst: rst, clk_en: en};

  rate_lock_tracker #(.COUNTER_WIDTH(16), .AVG_DEPTH_LOG2(2), .LOCK_COUNT(4)) dut (
    .sys_dom_i                     (dom),
    .track_en_i                    (track_en),
    .edge_i                        (edge_in),
    .edge_level_i                  (edge_level),
    .pause_polarity_i              (pause_pol),
    .minimum_half_rate_minus_one_i (min_hr),
    .maximum_half_rate_minus_one_i (max_hr),
    .minimum_pause_cycles_i        (pause_cyc),
    .busy_o                        (busy),
    .locked_o                      (locked),
    .paused_o                      (paused),
    .half_rate_minus_one_o         (hr),
    .half_rate_valid_o             (hr_valid),
    .high_half_rate_minus_one_o    (high_hr),
    .low_half_rate_minus_one_o     (low_hr),
    .violation_o                   (viol),
    .violation_code_o              (viol_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit viol;
    int val;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   line = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_rate(input int after, input int v);
    sb.push_back('{viol: 1'b0, val: v, cyc: cyc + after});
  endtask

  task automatic expect_viol(input int after, input int code);
    sb.push_back('{viol: 1'b1, val: code, cyc: cyc + after});
  endtask

  task automatic step(input bit e);
    exp_t x;
    edge_in    = e;
    edge_level = line;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      x = sb.pop_front();
      if (x.viol) begin
        check_eq("viol_pulse", viol, 1);
        check_eq("viol_no_valid", hr_valid, 0);
        check_eq("viol_code", viol_code, x.val);
      end else begin
        check_eq("rate_valid", hr_valid, 1);
        check_eq("rate_no_viol", viol, 0);
        check_eq("rate_value", hr, x.val);
      end
    end else if (hr_valid || viol) begin
      check_eq("unexpected_pulse", {hr_valid, viol}, 0);
    end
    edge_in = 1'b0;
  endtask

  task automatic edge_after(input int n, input bit lvl);
    for (int i = 0; i < n - 1; i++) step(1'b0);
    line = lvl;
    step(1'b1);
  endtask

  task automatic restart();
    track_en = 1'b0;
    step(1'b0);
    check_eq("idle_busy", busy, 0);
    track_en = 1'b1;
    step(1'b0);
    check_eq("acq_busy", busy, 1);
  endtask

  task automatic lock_seq();
    edge_after(3, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      expect_rate(10, 9);
      edge_after(10, k[0]);
      check_eq("lock_progress", locked, (k == 4) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; track_en = 1'b0; edge_in = 1'b0; edge_level = 1'b0;
    pause_pol = 1'b1; min_hr = 16'd3; max_hr = 16'd20; pause_cyc = 16'd50;
    step(1'b0);
    step(1'b0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_paused", paused, 0);
    check_eq("rst_rate", hr, 0);
    check_eq("rst_valid", hr_valid, 0);
    check_eq("rst_viol", viol, 0);
    check_eq("rst_code", viol_code, 0);
    check_eq("rst_high", high_hr, 0);
    check_eq("rst_low", low_hr, 0);
    rst = 1'b0;

    // lock on a 10-cycle edge spacing, then keep tracking the average
    track_en = 1'b1;
    step(1'b0);
    check_eq("acq_busy", busy, 1);
    lock_seq();
    expect_rate(10, 9);
    edge_after(10, 1'b1);

    // hold at the pause level for 60 cycles
    repeat (50) step(1'b0);
    check_eq("pause_not_yet", paused, 0);
    step(1'b0);
    check_eq("paused", paused, 1);
    check_eq("paused_locked", locked, 1);
    repeat (9) step(1'b0);
    check_eq("paused_hold", paused, 1);
    line = 1'b0;
    step(1'b1);
    check_eq("unpause_paused", paused, 0);
    check_eq("unpause_locked", locked, 1);
    check_eq("unpause_avg", hr, 9);
    expect_rate(10, 9);
    edge_after(10, 1'b1);

    // disabled cycles hold everything, edges on them are ignored
    repeat (4) step(1'b0);
    en = 1'b0;
    step(1'b1);
    step(1'b0);
    step(1'b1);
    check_eq("clken_hold_rate", hr, 9);
    check_eq("clken_hold_lock", locked, 1);
    en = 1'b1;
    expect_rate(5, 8);
    repeat (4) step(1'b0);
    line = 1'b1;
    step(1'b1);

    // too-short sample while locked
    expect_viol(2, 1);
    edge_after(2, 1'b0);
    check_eq("short_locked", locked, 0);
    check_eq("short_busy", busy, 1);
    check_eq("short_paused", paused, 0);

    // sample bounds inclusive; a violation in ACQUIRE clears the lock count
    restart();
    edge_after(3, 1'b1);
    expect_rate(21, 20);
    edge_after(21, 1'b0);
    expect_rate(4, 3);
    edge_after(4, 1'b1);
    expect_viol(3, 1);
    edge_after(3, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      expect_rate(10, 9);
      edge_after(10, k[0]);
      check_eq("relock_progress", locked, (k == 4) ? 1 : 0);
    end

    // edge on the timeout cycle wins: too long, not timeout
    restart();
    lock_seq();
    expect_viol(22, 2);
    edge_after(22, 1'b1);
    check_eq("long_locked", locked, 0);

    // no edge at the non-pause level: timeout
    restart();
    lock_seq();
    expect_viol(22, 3);
    repeat (22) step(1'b0);
    check_eq("timeout_locked", locked, 0);
    check_eq("timeout_busy", busy, 1);

    // asymmetric phases: high 6, low 12
    restart();
    edge_after(3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      expect_rate(k[0] ? 12 : 6, k[0] ? 11 : 5);
      edge_after(k[0] ? 12 : 6, k[0]);
    end
    check_eq("pwm_locked", locked, 1);
    expect_rate(6, 8);
    edge_after(6, 1'b0);
    expect_rate(12, 8);
    edge_after(12, 1'b1);
`ifdef RATE_LOCK_TRACKER_PWM_EN
    check_eq("pwm_high", high_hr, 5);
    check_eq("pwm_low", low_hr, 11);
`else
    check_eq("pwm_high_tied", high_hr, 0);
    check_eq("pwm_low_tied", low_hr, 0);
`endif

    // reset while locked
    rst = 1'b1;
    step(1'b0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_locked", locked, 0);
    check_eq("midrst_paused", paused, 0);
    check_eq("midrst_rate", hr, 0);
    check_eq("midrst_high", high_hr, 0);
    check_eq("midrst_low", low_hr, 0);
    check_eq("midrst_valid", hr_valid, 0);
    check_eq("midrst_viol", viol, 0);
    rst = 1'b0;
    step(1'b0);

    check_eq("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
